// File: rtl/axi_rd_arb_if.sv
// rtl/axi_rd_arb_if.sv - bus bundle between two AXI read masters, the arbiter and one AXI read slave
//
// Purpose: carries every address/read-data handshake signal of the arbiter.
//   m_* fields are packed per master: master i occupies slice i of each vector.
//   s_* fields are the single downstream slave port.
// Modports:
//   master : the arbiter's view (it masters the shared slave and answers the two masters)
//   slave  : the environment's view (upstream masters plus the downstream slave)
interface axi_rd_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [2*ADDR_W-1:0] m_ARADDR;
  logic [15:0]         m_ARLEN;
  logic [5:0]          m_ARSIZE;
  logic [3:0]          m_ARBURST;
  logic [1:0]          m_ARVALID;
  logic [1:0]          m_ARREADY;
  logic [2*DATA_W-1:0] m_RDATA;
  logic [3:0]          m_RRESP;
  logic [1:0]          m_RVALID;
  logic [1:0]          m_RREADY;

  logic [ADDR_W-1:0]   s_ARADDR;
  logic [7:0]          s_ARLEN;
  logic [2:0]          s_ARSIZE;
  logic [1:0]          s_ARBURST;
  logic                s_ARVALID;
  logic                s_ARREADY;
  logic [DATA_W-1:0]   s_RDATA;
  logic [1:0]          s_RRESP;
  logic                s_RVALID;
  logic                s_RREADY;

  modport master (
    input  m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARVALID, m_RREADY,
    input  s_ARREADY, s_RDATA, s_RRESP, s_RVALID,
    output m_ARREADY, m_RDATA, m_RRESP, m_RVALID,
    output s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARVALID, s_RREADY
  );

  modport slave (
    output m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARVALID, m_RREADY,
    output s_ARREADY, s_RDATA, s_RRESP, s_RVALID,
    input  m_ARREADY, m_RDATA, m_RRESP, m_RVALID,
    input  s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARVALID, s_RREADY
  );
endinterface

// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - two-master AXI read arbiter sharing one slave, one transaction in flight
//
// Purpose: grants the shared read slave to one of two masters per burst. A tie
//   goes to the master that did not win last time. The address phase and all
//   read beats are routed combinationally between the granted master and the slave.
// Ports:
//   ACLK   : clock, all state changes on the rising edge
//   ARESET : synchronous active-high reset
//   bus    : axi_rd_arb_if.master, both upstream masters and the downstream slave
module axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          ACLK,
  input  logic          ARESET,
  axi_rd_arb_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state_q, state_d;
  logic       g_q, g_d;       // granted master
  logic       lg_q, lg_d;     // master granted by the last completed burst
  logic [8:0] cnt_q, cnt_d;   // beats still owed by the slave

  // Fields of the granted master, selected once and reused below.
  logic [ADDR_W-1:0] addr_g;
  logic [7:0]        len_g;
  logic [2:0]        size_g;
  logic [1:0]        burst_g;
  logic              arvalid_g;
  logic              rready_g;
  // Outputs are forced quiet while reset is held, even before the state flop clears.
  logic              live;

  assign addr_g    = g_q ? bus.m_ARADDR[2*ADDR_W-1:ADDR_W] : bus.m_ARADDR[ADDR_W-1:0];
  assign len_g     = g_q ? bus.m_ARLEN[15:8]   : bus.m_ARLEN[7:0];
  assign size_g    = g_q ? bus.m_ARSIZE[5:3]   : bus.m_ARSIZE[2:0];
  assign burst_g   = g_q ? bus.m_ARBURST[3:2]  : bus.m_ARBURST[1:0];
  assign arvalid_g = g_q ? bus.m_ARVALID[1]    : bus.m_ARVALID[0];
  assign rready_g  = g_q ? bus.m_RREADY[1]     : bus.m_RREADY[0];
  assign live      = ~ARESET;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      lg_q    <= 1'b1;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    lg_d          = lg_q;
    cnt_d         = cnt_q;
    bus.m_ARREADY = '0;
    bus.m_RDATA   = '0;
    bus.m_RRESP   = '0;
    bus.m_RVALID  = '0;
    bus.s_ARADDR  = '0;
    bus.s_ARLEN   = '0;
    bus.s_ARSIZE  = '0;
    bus.s_ARBURST = '0;
    bus.s_ARVALID = 1'b0;
    bus.s_RREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.m_ARVALID) begin
          // Both requesting: alternate away from the last winner.
          g_d     = (&bus.m_ARVALID) ? ~lg_q : bus.m_ARVALID[1];
          state_d = ADDR;
        end
      end

      ADDR: begin
        bus.s_ARADDR  = addr_g;
        bus.s_ARLEN   = len_g;
        bus.s_ARSIZE  = size_g;
        bus.s_ARBURST = burst_g;
        bus.s_ARVALID = arvalid_g & live;
        if (g_q) bus.m_ARREADY[1] = bus.s_ARREADY & live;
        else     bus.m_ARREADY[0] = bus.s_ARREADY & live;
        // A withdrawn request simply holds the grant here until it returns.
        if (arvalid_g && bus.s_ARREADY) begin
          cnt_d   = {1'b0, len_g} + 9'd1;
          state_d = DATA;
        end
      end

      DATA: begin
        bus.s_RREADY = rready_g & live;
        if (g_q) begin
          bus.m_RDATA[2*DATA_W-1:DATA_W] = bus.s_RDATA;
          bus.m_RRESP[3:2]               = bus.s_RRESP;
          bus.m_RVALID[1]                = bus.s_RVALID & live;
        end else begin
          bus.m_RDATA[DATA_W-1:0]        = bus.s_RDATA;
          bus.m_RRESP[1:0]               = bus.s_RRESP;
          bus.m_RVALID[0]                = bus.s_RVALID & live;
        end
        // Burst length is fixed by ARLEN; error responses do not end it early.
        if (bus.s_RVALID && rready_g) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            lg_d    = g_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all AR address fields.
REQ-002 Parameter DATA_W, default 32, read data width of all R data fields.
REQ-003 ACLK  in  1  single clock; all state updates on rising edge.
REQ-004 ARESET  in  1  synchronous, active-high reset.
REQ-005 m_ARADDR  in  2*ADDR_W  master i address at [i*ADDR_W +: ADDR_W].
REQ-006 m_ARLEN  in  16  master i burst length-1 at [i*8 +: 8].
REQ-007 m_ARSIZE  in  6  master i beat size at [i*3 +: 3].
REQ-008 m_ARBURST  in  4  master i burst type at [i*2 +: 2].
REQ-009 m_ARVALID  in  2  per-master address valid.
REQ-010 m_ARREADY  out  2  per-master address ready.
REQ-011 m_RDATA  out  2*DATA_W  master i read data at [i*DATA_W +: DATA_W].
REQ-012 m_RRESP  out  4  master i read response at [i*2 +: 2].
REQ-013 m_RVALID  out  2  per-master read valid.
REQ-014 m_RREADY  in  2  per-master read ready.
REQ-015 s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST  out  ADDR_W/8/3/2  address fields to slave.
REQ-016 s_ARVALID  out  1 / s_ARREADY  in  1  slave address handshake.
REQ-017 s_RDATA  in  DATA_W / s_RRESP  in  2  slave read data and response.
REQ-018 s_RVALID  in  1 / s_RREADY  out  1  slave read handshake.

Function
REQ-019 Block SHALL share one AXI read slave between two masters, one outstanding transaction at a time.
REQ-020 FSM states SHALL be IDLE, ADDR, DATA; grant register g (1 bit), last-grant register lg (1 bit), beat counter cnt (9 bits).
REQ-021 IDLE: if any m_ARVALID, SHALL register g (sole requester, else master !lg on tie) and enter ADDR next cycle; otherwise stay IDLE.
REQ-022 ADDR: s_AR* fields and s_ARVALID SHALL equal master g's combinationally; m_ARREADY[g]=s_ARREADY.
REQ-023 ADDR: on s_ARVALID&&s_ARREADY, SHALL load cnt=ARLEN[g]+1 (zero-extended, range 1..256) and enter DATA.
REQ-024 ADDR: if m_ARVALID[g] deasserts before handshake, SHALL remain in ADDR with g unchanged.
REQ-025 DATA: m_RDATA/m_RRESP/m_RVALID of master g SHALL equal s_RDATA/s_RRESP/s_RVALID combinationally; s_RREADY=m_RREADY[g]; zero added latency.
REQ-026 DATA: each s_RVALID&&s_RREADY SHALL decrement cnt; handshake with cnt==1 SHALL set lg=g and enter IDLE.
REQ-027 Non-granted master SHALL see ARREADY=0, RVALID=0, RDATA=0, RRESP=0 in every state.
REQ-028 s_ARVALID SHALL be 0 outside ADDR; s_RREADY SHALL be 0 outside DATA.
REQ-029 Error RRESP (SLVERR/DECERR) SHALL pass through unchanged and SHALL NOT shorten the burst.
REQ-030 Grant SHALL change only in IDLE; address-to-slave latency SHALL be 1 cycle from ARVALID sampled in IDLE.
REQ-031 Back-to-back: IDLE entry after last beat SHALL cost one cycle before the next ADDR.

Reset
REQ-032 ARESET high SHALL force state=IDLE, g=0, lg=1 (master 0 wins first tie), cnt=0, next edge, from any state.
REQ-033 During and after reset all m_ARREADY, m_RVALID, s_ARVALID, s_RREADY SHALL be 0; in-flight slave beats are not drained.

Verification
REQ-034 Reset; m0 ARADDR=0x100 ARLEN=3 -> s_ARVALID 1 cycle later with 0x100; 4 R beats routed to m0 only; IDLE after 4th.
REQ-035 Both ARVALID held continuously after reset -> grants m0,m1,m0,m1; each burst completes before next s_ARVALID.
REQ-036 ARLEN=255 -> exactly 256 beats before release; ARLEN=0 -> exactly 1 beat.
REQ-037 m1 granted, m1 RREADY low 3 cycles mid-burst -> s_RREADY low 3 cycles, cnt unchanged, burst length preserved.
REQ-038 ARESET in DATA after 2 of 4 beats -> next cycle all valid/ready outputs 0, IDLE; subsequent tie grants m0.
REQ-039 s_RRESP=2'b10 on beat 2 of 4 -> m0 sees RRESP=2'b10 on beat 2; all 4 beats still delivered.
